register_free_list: RTL and testbench

REGISTER_FREE_LIST -- requirements
Module: register_free_list

---
 rtl/register_free_list_pkg.sv | 14 +
 rtl/register_free_list.sv | 157 +++++++++++++++
 tb/tb_register_free_list.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_free_list_pkg.sv
// Shared core renaming constants for the physical register free list.
package register_free_list_pkg;

  localparam int CORE_PREG_W    = 6;
  localparam int CORE_LREG_NUM  = 32;
  localparam int CORE_DEPTH     = 32;
  localparam int CORE_INIT_BASE = 32;

  typedef enum logic {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } fl_state_e;

endpackage : register_free_list_pkg

// File: rtl/register_free_list.sv
// Physical register free list: circular buffer of free names with a
// speculative head (rename), a commit head (retire) and a tail (names
// returned by retiring instructions). A flush rolls the speculative head
// back to the commit head.
//
// state   | meaning
// --------+--------------------------------------------------------------
// FL_INIT | first clock after reset: load names BASE..BASE+DEPTH-1, tail=DEPTH
// FL_RUN  | normal allocate / commit / restart operation
module register_free_list
  import register_free_list_pkg::*;
#(
  parameter int PREG_W = CORE_PREG_W,
  parameter int DEPTH  = CORE_DEPTH
) (
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              iRESTART_VALID,
  input  logic              iLOCK,
  input  logic              iALLOC_0_VALID,
  input  logic              iALLOC_1_VALID,
  output logic              oALLOC_READY,
  output logic [PREG_W-1:0] oALLOC_0_REGNAME,
  output logic [PREG_W-1:0] oALLOC_1_REGNAME,
  input  logic              iCOMMIT_0_VALID,
  input  logic              iCOMMIT_1_VALID,
  input  logic [PREG_W-1:0] iCOMMIT_0_OLD_REGNAME,
  input  logic [PREG_W-1:0] iCOMMIT_1_OLD_REGNAME,
  output logic [PREG_W-1:0] oFREE_COUNT
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  fl_state_e         b_state;
  fl_state_e         state_nxt;

  ptr_t              b_head;
  ptr_t              b_commit_head;
  ptr_t              b_tail;
  ptr_t              head_nxt;
  ptr_t              commit_head_nxt;
  ptr_t              tail_nxt;
  ptr_t              head_p1;
  ptr_t              wr_ptr1;
  ptr_t              free_cnt;
  ptr_t              outstanding;

  logic [1:0]        n_alloc;
  logic [1:0]        n_commit;
  logic              alloc_fire;
  logic              ready;
  logic [PREG_W-1:0] name0;
  logic [PREG_W-1:0] name1;

  logic [PREG_W-1:0] mem [DEPTH];

  assign free_cnt    = b_tail - b_head;
  assign outstanding = b_tail - b_commit_head;
  assign head_p1     = b_head + ptr_t'(1);

  // FSM state register
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_state <= FL_INIT;
    end else begin
      b_state <= state_nxt;
    end
  end

  // FSM next state: INIT lasts exactly one clock
  always_comb begin
    state_nxt = b_state;
    if (b_state == FL_INIT) begin
      state_nxt = FL_RUN;
    end
  end

  // FSM outputs: readiness and head names, held at zero until the list is loaded
  always_comb begin
    ready = 1'b0;
    name0 = '0;
    name1 = '0;
    if (b_state == FL_RUN) begin
      ready = (free_cnt >= ptr_t'(2));
      name0 = mem[b_head[IDX_W-1:0]];
      name1 = mem[head_p1[IDX_W-1:0]];
    end
  end

  // A lone slot-1 request takes the head entry, i.e. the name shown on
  // oALLOC_0_REGNAME; the head only ever advances by the request count.
  assign oALLOC_READY     = ready;
  assign oALLOC_0_REGNAME = name0;
  assign oALLOC_1_REGNAME = name1;
  assign oFREE_COUNT      = PREG_W'(free_cnt);

  // Next pointer values; commits always proceed, restart overrides allocation
  always_comb begin
    alloc_fire      = ready && !iLOCK && !iRESTART_VALID;
    n_alloc         = alloc_fire ? ({1'b0, iALLOC_0_VALID} + {1'b0, iALLOC_1_VALID}) : 2'd0;
    n_commit        = {1'b0, iCOMMIT_0_VALID} + {1'b0, iCOMMIT_1_VALID};
    commit_head_nxt = b_commit_head + {{(PTR_W-2){1'b0}}, n_commit};
    tail_nxt        = b_tail + {{(PTR_W-2){1'b0}}, n_commit};
    wr_ptr1         = b_tail + {{(PTR_W-1){1'b0}}, iCOMMIT_0_VALID};
    if (iRESTART_VALID) begin
      head_nxt = commit_head_nxt;
    end else begin
      head_nxt = b_head + {{(PTR_W-2){1'b0}}, n_alloc};
    end
  end

  // Pointer registers; INIT places the tail one full lap past the heads
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      b_head        <= '0;
      b_commit_head <= '0;
      b_tail        <= '0;
    end else if (b_state == FL_INIT) begin
      b_head        <= '0;
      b_commit_head <= '0;
      b_tail        <= ptr_t'(DEPTH);
    end else begin
      b_head        <= head_nxt;
      b_commit_head <= commit_head_nxt;
      b_tail        <= tail_nxt;
    end
  end

  // Name storage: bulk load in INIT, otherwise two commit write ports at the tail
  always_ff @(posedge iCLOCK) begin
    if (b_state == FL_INIT) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= PREG_W'(CORE_INIT_BASE + i);
      end
    end else begin
      if (iCOMMIT_0_VALID) begin
        mem[b_tail[IDX_W-1:0]] <= iCOMMIT_0_OLD_REGNAME;
      end
      if (iCOMMIT_1_VALID) begin
        mem[wr_ptr1[IDX_W-1:0]] <= iCOMMIT_1_OLD_REGNAME;
      end
    end
  end

  a_full_lap : assert property (@(posedge iCLOCK) disable iff (!inRESET)
    (b_state == FL_RUN) |-> (outstanding == ptr_t'(DEPTH)));

  a_commit_order : assert property (@(posedge iCLOCK) disable iff (!inRESET)
    !(iCOMMIT_1_VALID && !iCOMMIT_0_VALID));

  a_no_grant_no_move : assert property (@(posedge iCLOCK) disable iff (!inRESET)
    ((b_state == FL_RUN) && !ready && !iRESTART_VALID) |=> (b_head == $past(b_head)));

endmodule : register_free_list

// File: tb/tb_register_free_list.sv
// Bench for register_free_list: directed scenarios with fixed expectations,
// then randomized traffic against a queue-based model of the free list.
module tb_register_free_list;

  localparam int PW = 6;

  logic          iCLOCK = 1'b0;
  logic          inRESET = 1'b0;
  logic          iRESTART_VALID = 1'b0;
  logic          iLOCK = 1'b0;
  logic          iALLOC_0_VALID = 1'b0;
  logic          iALLOC_1_VALID = 1'b0;
  logic          oALLOC_READY;
  logic [PW-1:0] oALLOC_0_REGNAME;
  logic [PW-1:0] oALLOC_1_REGNAME;
  logic          iCOMMIT_0_VALID = 1'b0;
  logic          iCOMMIT_1_VALID = 1'b0;
  logic [PW-1:0] iCOMMIT_0_OLD_REGNAME = '0;
  logic [PW-1:0] iCOMMIT_1_OLD_REGNAME = '0;
  logic [PW-1:0] oFREE_COUNT;

  int compared = 0;
  int mismatched = 0;

  // model: queue of names from the commit head to the tail, plus count of
  // entries handed out speculatively from its front
  int q[$];
  int spec_taken;

  register_free_list dut (
    .iCLOCK               (iCLOCK),
    .inRESET              (inRESET),
    .iRESTART_VALID       (iRESTART_VALID),
    .iLOCK                (iLOCK),
    .iALLOC_0_VALID       (iALLOC_0_VALID),
    .iALLOC_1_VALID       (iALLOC_1_VALID),
    .oALLOC_READY         (oALLOC_READY),
    .oALLOC_0_REGNAME     (oALLOC_0_REGNAME),
    .oALLOC_1_REGNAME     (oALLOC_1_REGNAME),
    .iCOMMIT_0_VALID      (iCOMMIT_0_VALID),
    .iCOMMIT_1_VALID      (iCOMMIT_1_VALID),
    .iCOMMIT_0_OLD_REGNAME(iCOMMIT_0_OLD_REGNAME),
    .iCOMMIT_1_OLD_REGNAME(iCOMMIT_1_OLD_REGNAME),
    .oFREE_COUNT          (oFREE_COUNT)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic drive(input logic a0, input logic a1, input logic lk, input logic rs,
                       input logic c0, input logic c1, input int o0, input int o1);
    iALLOC_0_VALID        = a0;
    iALLOC_1_VALID        = a1;
    iLOCK                 = lk;
    iRESTART_VALID        = rs;
    iCOMMIT_0_VALID       = c0;
    iCOMMIT_1_VALID       = c1;
    iCOMMIT_0_OLD_REGNAME = PW'(o0);
    iCOMMIT_1_OLD_REGNAME = PW'(o1);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    inRESET = 1'b0;
    tick();
    tick();
    inRESET = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    inRESET = 1'b0;
    #3;
    compared++;
    if (oALLOC_READY !== 1'b0) begin
      mismatched++; $display("FAIL reset_ready got %b want 0", oALLOC_READY);
    end
    compared++;
    if (oFREE_COUNT !== 6'd0) begin
      mismatched++; $display("FAIL reset_free got %0d want 0", oFREE_COUNT);
    end
    tick();
    compared++;
    if (oALLOC_0_REGNAME !== 6'd0 || oALLOC_1_REGNAME !== 6'd0) begin
      mismatched++;
      $display("FAIL reset_names got %0d/%0d want 0/0", oALLOC_0_REGNAME, oALLOC_1_REGNAME);
    end
  endtask

  task automatic test_init();
    tick();
    inRESET = 1'b1;
    // requests during INIT must be ignored
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    compared++;
    if (oALLOC_READY !== 1'b0) begin
      mismatched++; $display("FAIL init_ready got %b want 0", oALLOC_READY);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (oALLOC_READY !== 1'b1 || oFREE_COUNT !== 6'd32) begin
      mismatched++;
      $display("FAIL init_state got ready=%b free=%0d want ready=1 free=32", oALLOC_READY, oFREE_COUNT);
    end
    compared++;
    if (oALLOC_0_REGNAME !== 6'd32 || oALLOC_1_REGNAME !== 6'd33) begin
      mismatched++;
      $display("FAIL init_names got %0d/%0d want 32/33", oALLOC_0_REGNAME, oALLOC_1_REGNAME);
    end
  endtask

  task automatic test_drain();
    int bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (oALLOC_0_REGNAME !== PW'(32 + 2 * k) || oALLOC_1_REGNAME !== PW'(33 + 2 * k)) begin
        bad++;
        $display("FAIL drain_names step %0d got %0d/%0d want %0d/%0d", k,
                 oALLOC_0_REGNAME, oALLOC_1_REGNAME, 32 + 2 * k, 33 + 2 * k);
      end
      drive(1, 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    compared++;
    if (bad != 0) mismatched++;
    compared++;
    if (oALLOC_READY !== 1'b0 || oFREE_COUNT !== 6'd0) begin
      mismatched++;
      $display("FAIL drain_empty got ready=%b free=%0d want 0/0", oALLOC_READY, oFREE_COUNT);
    end
  endtask

  task automatic test_commit_wrap();
    // requests stay asserted: with nothing free they must not be granted
    drive(1, 1, 0, 0, 1, 1, 5, 6);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (oFREE_COUNT !== 6'd2 || oALLOC_READY !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_free got free=%0d ready=%b want 2/1", oFREE_COUNT, oALLOC_READY);
    end
    compared++;
    if (oALLOC_0_REGNAME !== 6'd5 || oALLOC_1_REGNAME !== 6'd6) begin
      mismatched++;
      $display("FAIL wrap_names got %0d/%0d want 5/6", oALLOC_0_REGNAME, oALLOC_1_REGNAME);
    end
    // lone slot-1 request consumes one name, leaving a single free entry
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    compared++;
    if (oFREE_COUNT !== 6'd1 || oALLOC_READY !== 1'b0) begin
      mismatched++;
      $display("FAIL one_left got free=%0d ready=%b want 1/0", oFREE_COUNT, oALLOC_READY);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    compared++;
    if (oFREE_COUNT !== 6'd1) begin
      mismatched++; $display("FAIL one_left_hold got free=%0d want 1", oFREE_COUNT);
    end
    drive(0, 0, 0, 0, 1, 0, 9, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (oALLOC_READY !== 1'b1 || oALLOC_0_REGNAME !== 6'd6 || oALLOC_1_REGNAME !== 6'd9) begin
      mismatched++;
      $display("FAIL refill got ready=%b names %0d/%0d want 1 6/9",
               oALLOC_READY, oALLOC_0_REGNAME, oALLOC_1_REGNAME);
    end
  endtask

  task automatic test_restart();
    do_reset();
    compared++;
    if (oFREE_COUNT !== 6'd32 || oALLOC_0_REGNAME !== 6'd32 || oALLOC_1_REGNAME !== 6'd33) begin
      mismatched++;
      $display("FAIL midreset got free=%0d names %0d/%0d want 32 32/33",
               oFREE_COUNT, oALLOC_0_REGNAME, oALLOC_1_REGNAME);
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (oFREE_COUNT !== 6'd28 || oALLOC_0_REGNAME !== 6'd36) begin
      mismatched++;
      $display("FAIL alloc4 got free=%0d head=%0d want 28/36", oFREE_COUNT, oALLOC_0_REGNAME);
    end
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (oFREE_COUNT !== 6'd32 || oALLOC_0_REGNAME !== 6'd32 || oALLOC_1_REGNAME !== 6'd33) begin
      mismatched++;
      $display("FAIL restart got free=%0d names %0d/%0d want 32 32/33",
               oFREE_COUNT, oALLOC_0_REGNAME, oALLOC_1_REGNAME);
    end
  endtask

  task automatic test_restart_commit();
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 1, 1, 0, 7, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (oFREE_COUNT !== 6'd32 || oALLOC_0_REGNAME !== 6'd33 || oALLOC_1_REGNAME !== 6'd34) begin
      mismatched++;
      $display("FAIL restart_commit got free=%0d names %0d/%0d want 32 33/34",
               oFREE_COUNT, oALLOC_0_REGNAME, oALLOC_1_REGNAME);
    end
  endtask

  task automatic test_lock();
    int want_free[3] = '{30, 31, 31};
    int bad = 0;
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 0, k == 1, 0, 11, 0);
      tick();
      if (oFREE_COUNT !== PW'(want_free[k]) || oALLOC_0_REGNAME !== 6'd35 ||
          oALLOC_1_REGNAME !== 6'd36) begin
        bad++;
        $display("FAIL lock step %0d got free=%0d names %0d/%0d want %0d 35/36", k,
                 oFREE_COUNT, oALLOC_0_REGNAME, oALLOC_1_REGNAME, want_free[k]);
      end
    end
    compared++;
    if (bad != 0) mismatched++;
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (oFREE_COUNT !== 6'd29 || oALLOC_0_REGNAME !== 6'd37) begin
      mismatched++;
      $display("FAIL unlock got free=%0d head=%0d want 29/37", oFREE_COUNT, oALLOC_0_REGNAME);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int exp_free;
    logic a0, a1, lk, rs, c0, c1;
    int o0, o1;
    do_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    spec_taken = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_free = q.size() - spec_taken;
      if (oFREE_COUNT !== PW'(exp_free) || oALLOC_READY !== (exp_free >= 2)) begin
        bad++;
        $display("FAIL rand_state cyc %0d got free=%0d ready=%b want free=%0d ready=%b",
                 cyc, oFREE_COUNT, oALLOC_READY, exp_free, exp_free >= 2);
      end
      if (exp_free >= 2 && (oALLOC_0_REGNAME !== PW'(q[spec_taken]) ||
                            oALLOC_1_REGNAME !== PW'(q[spec_taken + 1]))) begin
        bad++;
        $display("FAIL rand_names cyc %0d got %0d/%0d want %0d/%0d", cyc,
                 oALLOC_0_REGNAME, oALLOC_1_REGNAME, q[spec_taken], q[spec_taken + 1]);
      end
      a0 = ($urandom_range(0, 3) != 0);
      a1 = ($urandom_range(0, 3) != 0);
      lk = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 19) == 0);
      c0 = (spec_taken >= 1) && ($urandom_range(0, 2) != 0);
      c1 = c0 && (spec_taken >= 2) && ($urandom_range(0, 1) != 0);
      o0 = $urandom_range(0, 63);
      o1 = $urandom_range(0, 63);
      drive(a0, a1, lk, rs, c0, c1, o0, o1);
      tick();
      if (exp_free >= 2 && !lk && !rs) spec_taken += int'(a0) + int'(a1);
      if (c0) begin void'(q.pop_front()); q.push_back(o0); spec_taken--; end
      if (c1) begin void'(q.pop_front()); q.push_back(o1); spec_taken--; end
      if (rs) spec_taken = 0;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (bad != 0) mismatched++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_drain();
    test_commit_wrap();
    test_restart();
    test_restart_commit();
    test_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_register_free_list
